cpu_run_ctrl: RTL

Board-level run controller for the multicycle MIPS CPU. It holds the CPU in reset for a fixed power-on delay, then releases it. It then either lets the CPU free-run or advances it one clock-enable per debounced `key_sure` press (single-step), selected by a switch. It replaces ad-hoc reset/delay logic in the board top and drives the CPU's `RST` and a clock-enable.

---
 rtl/cpu_run_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//   Board-level run controller for the multicycle MIPS CPU. It holds the CPU in
//   reset for DELAY_CYCLES after key_reset drops. It then either free-runs the
//   CPU or advances it by one clock-enable per debounced key_sure press,
//   selected by the mode_step switch.
//
//   Ports
//     CLK        in   system clock, the only clock
//     key_reset  in   synchronous active-high reset, returns to S_DELAY
//     key_sure   in   raw pushbutton (async), high = pressed
//     mode_step  in   raw switch (async), 1 = single-step, 0 = free-run
//     cpu_rst    out  to CPU RST: 0 holds the CPU in reset
//     cpu_ce     out  CPU advance enable
//     ce_count   out  cycles with cpu_ce=1 since reset, wraps at 16 bits
//     state      out  current FSM state (debug / LED)
//
//   Handshake: there is no valid/ready pair here. press is a one-cycle pulse
//   that is consumed only in S_IDLE; in any other state it is dropped.
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int DELAY_CYCLES    = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 100_000
) (
   input  logic        CLK,
   input  logic        key_reset,
   input  logic        key_sure,
   input  logic        mode_step,
   output logic        cpu_rst,
   output logic        cpu_ce,
   output logic [15:0] ce_count,
   output logic [1:0]  state
);

   localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_DELAY = 2'd0,
      S_RUN   = 2'd1,
      S_IDLE  = 2'd2,
      S_STEP  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic              deb_q, deb_d;
   logic              deb_prev_q;
   logic              k_s1_q, k_s2_q;
   logic              m_s1_q, m_s2_q;
   logic [15:0]       ce_count_q;
   logic              press;

   // Synchronizers, debounce state, run state and the enable counter.
   always_ff @(posedge CLK) begin
      if (key_reset) begin
         k_s1_q     <= 1'b0;
         k_s2_q     <= 1'b0;
         m_s1_q     <= 1'b0;
         m_s2_q     <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         deb_cnt_q  <= '0;
         dly_cnt_q  <= '0;
         state_q    <= S_DELAY;
         ce_count_q <= 16'd0;
      end else begin
         k_s1_q     <= key_sure;
         k_s2_q     <= k_s1_q;
         m_s1_q     <= mode_step;
         m_s2_q     <= m_s1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         deb_cnt_q  <= deb_cnt_d;
         dly_cnt_q  <= dly_cnt_d;
         state_q    <= state_d;
         // cpu_ce is decoded from state_q, so this counts enabled cycles exactly.
         ce_count_q <= ce_count_q + {15'd0, cpu_ce};
      end
   end

   // Debouncer: the counter only runs while the synchronized key disagrees
   // with the accepted level, so any bounce back resets it.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (k_s2_q != deb_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            deb_d     = k_s2_q;
            deb_cnt_d = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   // Rising edge of the accepted level only; release never steps.
   assign press = deb_q & ~deb_prev_q;

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      dly_cnt_d = '0;
      unique case (state_q)
         S_DELAY: begin
            if (dly_cnt_q == DLY_LAST) begin
               state_d = m_s2_q ? S_IDLE : S_RUN;
            end else begin
               dly_cnt_d = dly_cnt_q + DLY_W'(1);
            end
         end
         S_RUN: begin
            if (m_s2_q) state_d = S_IDLE;
         end
         S_IDLE: begin
            // A switch back to free-run takes priority over a coincident press.
            if (!m_s2_q)    state_d = S_RUN;
            else if (press) state_d = S_STEP;
         end
         S_STEP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_DELAY;
      endcase
   end

   // Moore outputs decoded from the state register only.
   always_comb begin
      cpu_rst = (state_q != S_DELAY);
      cpu_ce  = (state_q == S_RUN) || (state_q == S_STEP);
   end

   assign ce_count = ce_count_q;
   assign state    = state_q;

endmodule
